// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the round-robin floating-point add/sub arbiter.
package fp_arb_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } arb_state_t;

    typedef struct packed {
        logic f;
        logic zero;
        logic over;
        logic under;
    } fp_flags_t;

endpackage

// File: rtl/adder_floating_point.sv
// Combinational IEEE754 single add/subtract, round-to-nearest-even.
// Denormal inputs are treated as zero; results below the normal range flush to signed zero.
module adder_floating_point
    import fp_arb_pkg::*;
(
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic            sub,
    output logic [FP_W-1:0] result,
    output logic            f,
    output logic            zero,
    output logic            over,
    output logic            under
);

    logic              sa, sb, sl, ss;
    logic [7:0]        ea, eb, el, es, d;
    logic [23:0]       ma, mb, ml, ms;
    logic [49:0]       sh;
    logic [26:0]       al;
    logic [27:0]       sum;
    logic              nan_a, nan_b, inf_a, inf_b;
    logic [4:0]        lz;
    logic [26:0]       n;
    logic signed [9:0] e, ef;
    logic [24:0]       m;
    logic [22:0]       frac;
    logic              rup;

    assign sa    = a[31];
    assign sb    = b[31] ^ sub;
    assign ea    = a[30:23];
    assign eb    = b[30:23];
    assign ma    = (ea == '0) ? '0 : {1'b1, a[22:0]};
    assign mb    = (eb == '0) ? '0 : {1'b1, b[22:0]};
    assign nan_a = (ea == 8'hFF) && (a[22:0] != '0);
    assign nan_b = (eb == 8'hFF) && (b[22:0] != '0);
    assign inf_a = (ea == 8'hFF) && (a[22:0] == '0);
    assign inf_b = (eb == 8'hFF) && (b[22:0] == '0);

    // Order by magnitude so the subtraction below never goes negative.
    assign {sl, el, ml, ss, es, ms} = (a[30:0] >= b[30:0]) ? {sa, ea, ma, sb, eb, mb}
                                                           : {sb, eb, mb, sa, ea, ma};
    assign d   = el - es;
    assign sh  = {ms, 26'd0} >> d;
    assign al  = (d > 8'd26) ? {26'd0, |ms} : {sh[49:24], |sh[23:0]};
    assign sum = (sl ^ ss) ? ({1'b0, ml, 3'b000} - {1'b0, al})
                           : ({1'b0, ml, 3'b000} + {1'b0, al});

    always_comb begin
        result = '0;
        f      = 1'b0;
        zero   = 1'b0;
        over   = 1'b0;
        under  = 1'b0;
        lz     = '0;
        for (int unsigned k = 0; k < 27; k++) begin
            if (sum[k]) begin
                lz = 5'(26 - k);
            end
        end
        if (sum[27]) begin
            n = {sum[27:2], sum[1] | sum[0]};
            e = $signed({2'b00, el}) + 10'sd1;
        end else begin
            n = sum[26:0] << lz;
            e = $signed({2'b00, el}) - $signed({5'd0, lz});
        end
        // n[3] is the result lsb; n[2:0] are guard, round and sticky.
        rup  = n[2] & (n[1] | n[0] | n[3]);
        m    = {1'b0, n[26:3]} + {24'd0, rup};
        ef   = e + $signed({9'd0, m[24]});
        frac = m[24] ? m[23:1] : m[22:0];

        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
            result = 32'h7FC0_0000;
            f      = 1'b1;
        end else if (inf_a) begin
            result = {sa, 8'hFF, 23'd0};
        end else if (inf_b) begin
            result = {sb, 8'hFF, 23'd0};
        end else if (sum == '0) begin
            zero = 1'b1;
        end else if (ef >= 10'sd255) begin
            over   = 1'b1;
            result = {sl, 8'hFF, 23'd0};
        end else if (ef <= 10'sd0) begin
            under  = 1'b1;
            zero   = 1'b1;
            result = {sl, 31'd0};
        end else begin
            result = {sl, ef[7:0], frac};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin selector: first asserted request at or after the pointer, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    always_comb begin
        int unsigned c;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        c     = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!any && req[c]) begin
                any      = 1'b1;
                grant[c] = 1'b1;
                idx      = ID_W'(c);
            end
        end
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Shares one floating-point adder among NUM_REQ requesters with round-robin grants;
// one operation in flight, operands registered before and results after the adder.
module fp_addsub_arbiter
    import fp_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [FP_W-1:0]         rsp_result,
    output logic                    rsp_f,
    output logic                    rsp_zero,
    output logic                    rsp_over,
    output logic                    rsp_under,
    output logic                    busy
);

    arb_state_t         state, state_nxt;
    logic [ID_W-1:0]    rr_ptr, grant_idx, op_id;
    logic [NUM_REQ-1:0] grant;
    logic               grant_any, accept;
    logic [FP_W-1:0]    op_a, op_b, add_result;
    logic               op_sub;
    logic               add_f, add_zero, add_over, add_under;
    fp_flags_t          rsp_flags;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (grant_idx),
        .any   (grant_any)
    );

    adder_floating_point u_add (
        .a      (op_a),
        .b      (op_b),
        .sub    (op_sub),
        .result (add_result),
        .f      (add_f),
        .zero   (add_zero),
        .over   (add_over),
        .under  (add_under)
    );

    // Grants are gated by rst_n so req_ready reads 0 throughout reset.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst_n && grant_any) begin
                    accept    = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    if (rst_n && grant_any) begin
                        accept    = 1'b1;
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        req_ready = accept ? grant : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_sub     <= 1'b0;
            op_id      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
                op_a   <= req_a[grant_idx*FP_W +: FP_W];
                op_b   <= req_b[grant_idx*FP_W +: FP_W];
                op_sub <= req_sub[grant_idx];
                op_id  <= grant_idx;
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= op_id;
                rsp_result <= add_result;
                rsp_flags  <= {add_f, add_zero, add_over, add_under};
            end else if ((state == RESP) && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end

    assign rsp_f     = rsp_flags.f;
    assign rsp_zero  = rsp_flags.zero;
    assign rsp_over  = rsp_flags.over;
    assign rsp_under = rsp_flags.under;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Self-checking bench: directed cases, randomized ops against a real-arithmetic model,
// round-robin ordering, response back-pressure and reset mid-operation.
module tb_fp_addsub_arbiter;
    import fp_arb_pkg::*;

    localparam int N   = 4;
    localparam int IDW = 2;

    typedef struct packed {
        logic [31:0] r;
        logic        f, z, o, u;
    } exp_t;

    logic            clk, rst_n;
    logic [N-1:0]    req_valid, req_sub, req_ready;
    logic [N*32-1:0] req_a, req_b;
    logic            rsp_valid, rsp_ready, rsp_f, rsp_zero, rsp_over, rsp_under, busy;
    logic [IDW-1:0]  rsp_id;
    logic [31:0]     rsp_result;
    int              errors = 0;
    int              checks = 0;

    fp_addsub_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_sub(req_sub), .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_f(rsp_f), .rsp_zero(rsp_zero),
        .rsp_over(rsp_over), .rsp_under(rsp_under), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic real to_real(input logic [31:0] x);
        if (x[30:23] == 8'd0) return 0.0;
        return $bitstoreal({x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0});
    endfunction

    // Exact double sum (operand exponents kept close) rounded to single, nearest-even.
    function automatic exp_t fp_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
        real         r;
        logic [63:0] bits;
        int          e;
        logic [24:0] keep;
        exp_t        res;
        res = '0;
        r   = s ? (to_real(a) - to_real(b)) : (to_real(a) + to_real(b));
        if (r == 0.0) begin
            res.z = 1'b1;
            return res;
        end
        bits = $realtobits(r);
        e    = int'(bits[62:52]) - 896;
        keep = {2'b01, bits[51:29]};
        if (bits[28] && ((|bits[27:0]) || keep[0])) keep = keep + 25'd1;
        if (keep[24]) begin
            e    = e + 1;
            keep = keep >> 1;
        end
        if (e >= 255) begin
            res.r = {bits[63], 8'hFF, 23'd0};
            res.o = 1'b1;
        end else if (e <= 0) begin
            res.r = {bits[63], 31'd0};
            res.u = 1'b1;
            res.z = 1'b1;
        end else begin
            res.r = {bits[63], 8'(e), keep[22:0]};
        end
        return res;
    endfunction

    task automatic rand_pair(output logic [31:0] a, output logic [31:0] b);
        int ea, eb;
        ea = int'($urandom_range(100, 150));
        eb = ea + int'($urandom_range(0, 40)) - 20;
        a  = {1'($urandom), 8'(ea), 23'($urandom)};
        b  = {1'($urandom), 8'(eb), 23'($urandom)};
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drives one isolated request and samples the response channel; no checking here.
    task automatic run_single(input int i, input logic [31:0] a, input logic [31:0] b,
                              input logic s, output logic [N-1:0] g, output logic v1,
                              output logic v2, output logic v3, output logic [IDW-1:0] id,
                              output logic [35:0] obs);
        @(negedge clk);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_sub[i]        = s;
        req_valid         = N'(1) << i;
        rsp_ready         = 1'b0;
        #1 g = req_ready;
        @(negedge clk);
        req_valid         = '0;
        req_a[i*32 +: 32] = $urandom;
        req_b[i*32 +: 32] = $urandom;
        v1                = rsp_valid;
        @(negedge clk);
        v2        = rsp_valid;
        id        = rsp_id;
        obs       = {rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under};
        rsp_ready = 1'b1;
        @(negedge clk);
        v3        = rsp_valid | busy;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0; req_sub = '0; req_a = '0; req_b = '0;
        #2;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if ({rsp_id, rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under} !== 38'd0) begin
            errors++; $display("FAIL reset_rsp_data: id=%h result=%h flags=%b want all 0", rsp_id, rsp_result,
                               {rsp_f, rsp_zero, rsp_over, rsp_under});
        end
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        int          idx [3] = '{0, 2, 1};
        logic [31:0] av  [3] = '{32'h3F80_0000, 32'h3F80_0000, 32'h7F7F_FFFF};
        logic [31:0] bv  [3] = '{32'h4000_0000, 32'h3F80_0000, 32'h7F7F_FFFF};
        logic        sv  [3] = '{1'b0, 1'b1, 1'b0};
        logic [35:0] ev  [3] = '{36'h4_0400_0000, 36'h0_0000_0004, 36'h7_F800_0002};
        logic [N-1:0] g; logic v1, v2, v3; logic [IDW-1:0] id; logic [35:0] obs;
        for (int t = 0; t < 3; t++) begin
            run_single(idx[t], av[t], bv[t], sv[t], g, v1, v2, v3, id, obs);
            checks++; if (g !== N'(1) << idx[t]) begin errors++; $display("FAIL dir%0d_grant: got %b want %b", t, g, N'(1) << idx[t]); end
            checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL dir%0d_early_valid: got %b want 0", t, v1); end
            checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL dir%0d_latency: rsp_valid got %b want 1", t, v2); end
            checks++; if (id !== IDW'(idx[t])) begin errors++; $display("FAIL dir%0d_id: got %0d want %0d", t, id, idx[t]); end
            checks++; if (obs !== ev[t]) begin errors++; $display("FAIL dir%0d_result: got %h want %h", t, obs, ev[t]); end
            checks++; if (v3 !== 1'b0) begin errors++; $display("FAIL dir%0d_release: valid|busy got %b want 0", t, v3); end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] g; logic v1, v2, v3; logic [IDW-1:0] id; logic [35:0] obs;
        logic [31:0] a, b; logic s; int i; exp_t e;
        for (int k = 0; k < 40; k++) begin
            rand_pair(a, b);
            if (k % 8 == 0) b = a;
            s = 1'($urandom);
            i = int'($urandom_range(0, N - 1));
            e = fp_ref(a, b, s);
            run_single(i, a, b, s, g, v1, v2, v3, id, obs);
            checks++; if (g !== N'(1) << i) begin errors++; $display("FAIL rnd%0d_grant: got %b want %b", k, g, N'(1) << i); end
            checks++; if ({v1, v2, v3} !== 3'b010) begin errors++; $display("FAIL rnd%0d_timing: valid seq got %b want 010", k, {v1, v2, v3}); end
            checks++; if (id !== IDW'(i)) begin errors++; $display("FAIL rnd%0d_id: got %0d want %0d", k, id, i); end
            checks++; if (obs !== e) begin
                errors++; $display("FAIL rnd%0d_result: a=%h b=%h sub=%b got %h want %h", k, a, b, s, obs, e);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] a, b; exp_t e [N]; logic [N-1:0] eg; int gi;
        do_reset();
        for (int i = 0; i < N; i++) begin
            rand_pair(a, b);
            req_a[i*32 +: 32] = a; req_b[i*32 +: 32] = b; req_sub[i] = 1'($urandom);
            e[i] = fp_ref(a, b, req_sub[i]);
        end
        req_valid = '1;
        rsp_ready = 1'b1;
        for (int k = 0; k <= 10; k++) begin
            #1;
            eg = (k % 2 == 0) ? N'(1) << ((k / 2) % N) : '0;
            checks++; if (req_ready !== eg) begin errors++; $display("FAIL rr_grant_c%0d: got %b want %b", k, req_ready, eg); end
            checks++; if (rsp_valid !== (k >= 2 && k % 2 == 0)) begin errors++; $display("FAIL rr_valid_c%0d: got %b", k, rsp_valid); end
            if (k >= 2 && k % 2 == 0) begin
                gi = ((k / 2) - 1) % N;
                checks++; if (rsp_id !== IDW'(gi)) begin errors++; $display("FAIL rr_id_c%0d: got %0d want %0d", k, rsp_id, gi); end
                checks++; if ({rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under} !== e[gi]) begin
                    errors++; $display("FAIL rr_result_c%0d: got %h want %h", k, {rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under}, e[gi]);
                end
            end
            @(negedge clk);
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [31:0] a, b; exp_t e0, e1;
        do_reset();
        rand_pair(a, b); req_a[31:0] = a; req_b[31:0] = b; req_sub[0] = 1'b0; e0 = fp_ref(a, b, 1'b0);
        req_valid = 4'b0001; rsp_ready = 1'b0;
        @(negedge clk);
        rand_pair(a, b); req_a[63:32] = a; req_b[63:32] = b; req_sub[1] = 1'b1; e1 = fp_ref(a, b, 1'b1);
        rand_pair(a, b); req_a[127:96] = a; req_b[127:96] = b;
        req_valid = 4'b1010;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_c%0d: got %b want 1", k, rsp_valid); end
            checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_c%0d: got %b want 0000", k, req_ready); end
            checks++; if ({rsp_id, rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under} !== {2'd0, e0}) begin
                errors++; $display("FAIL bp_hold_c%0d: id=%0d data=%h want id=0 data=%h", k, rsp_id,
                                   {rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under}, e0);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_accept: got %b want 0010", req_ready); end
        @(negedge clk);
        rsp_ready = 1'b0;
        checks++; if ({rsp_valid, busy} !== 2'b01) begin errors++; $display("FAIL bp_exec: valid,busy got %b want 01", {rsp_valid, busy}); end
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id} !== {1'b1, 2'd1}) begin errors++; $display("FAIL bp_resp2: valid,id got %b,%0d want 1,1", rsp_valid, rsp_id); end
        checks++; if ({rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under} !== e1) begin
            errors++; $display("FAIL bp_result2: got %h want %h", {rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under}, e1);
        end
        req_valid = '0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] a, b; exp_t e0;
        do_reset();
        for (int i = 0; i < N; i++) begin
            rand_pair(a, b); req_a[i*32 +: 32] = a; req_b[i*32 +: 32] = b; req_sub[i] = 1'b0;
        end
        e0 = fp_ref(req_a[31:0], req_b[31:0], 1'b0);
        req_valid = 4'b0100; rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 4'b1000;
        @(negedge clk);
        @(negedge clk);
        req_valid = '1;
        rst_n     = 1'b0;
        #1;
        checks++; if ({rsp_valid, req_ready, busy} !== 6'd0) begin
            errors++; $display("FAIL rstmid_ctrl: valid=%b ready=%b busy=%b want 0", rsp_valid, req_ready, busy);
        end
        checks++; if ({rsp_id, rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under} !== 38'd0) begin
            errors++; $display("FAIL rstmid_data: id=%0d result=%h want 0", rsp_id, rsp_result);
        end
        @(negedge clk);
        rst_n = 1'b1; req_valid = '0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_rsp_c%0d: got %b want 0", k, rsp_valid); end
        end
        req_valid = '1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rstmid_next_grant: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        checks++; if ({rsp_valid, rsp_id} !== 3'b100) begin errors++; $display("FAIL rstmid_rsp: valid,id got %b,%0d want 1,0", rsp_valid, rsp_id); end
        checks++; if ({rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under} !== e0) begin
            errors++; $display("FAIL rstmid_result: got %h want %h", {rsp_result, rsp_f, rsp_zero, rsp_over, rsp_under}, e0);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
